// File: rtl/led_switch_io.sv
// Board-side IO peripheral: latches the 24 LEDs from router store data and serves
// synchronised, debounced DIP switch values plus a sticky change flag.
module led_switch_io #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        led_ctrl,
  input  logic [23:0] led_wdata,
  input  logic        switch_ctrl,
  input  logic [23:0] switch_in,
  output logic [23:0] switch_rdata,
  output logic        sw_changed,
  output logic [23:0] led_out
);

  logic [23:0]      led_reg;
  logic [23:0]      sync1;
  logic [23:0]      sync2;
  logic [23:0]      sample_prev;
  logic [23:0]      sw_stable;
  logic [CNT_W-1:0] tick_cnt;
  logic             changed;
  logic             tick;
  logic             accept;

  assign tick   = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign accept = tick && (sync2 == sample_prev) && (sync2 != sw_stable);

  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg <= '0;
    end else if (led_ctrl) begin
      led_reg <= led_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
    end
  end

  // Free-running sample tick; never gated by any strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // A vector is accepted only after matching on two consecutive ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_prev <= '0;
      sw_stable   <= '0;
    end else if (tick) begin
      sample_prev <= sync2;
      if (accept) begin
        sw_stable <= sync2;
      end
    end
  end

  // A new debounced value beats a clearing read on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      changed <= 1'b0;
    end else if (accept) begin
      changed <= 1'b1;
    end else if (switch_ctrl) begin
      changed <= 1'b0;
    end
  end

  assign led_out      = led_reg;
  assign switch_rdata = sw_stable;
  assign sw_changed   = changed;

endmodule

// File: tb/tb_led_switch_io.sv
// Self-checking bench for led_switch_io: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the peripheral.
module tb_led_switch_io;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        led_ctrl;
  logic [23:0] led_wdata;
  logic        switch_ctrl;
  logic [23:0] switch_in;
  logic [23:0] switch_rdata;
  logic        sw_changed;
  logic [23:0] led_out;

  int vectors = 0;
  int miscompares = 0;

  led_switch_io #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .led_ctrl    (led_ctrl),
    .led_wdata   (led_wdata),
    .switch_ctrl (switch_ctrl),
    .switch_in   (switch_in),
    .switch_rdata(switch_rdata),
    .sw_changed  (sw_changed),
    .led_out     (led_out)
  );

  always #5 clock = ~clock;

  // Behavioural model: edge index since reset decides tick edges; a pin value is
  // seen by the debouncer two edges after it is captured.
  logic [23:0] m_led;
  logic [23:0] m_stable;
  logic        m_changed;
  logic [23:0] m_prev;
  logic [23:0] hist [2];
  int          k = 0;
  bit          started = 0;

  always @(posedge clock) begin
    bit accept_now;
    started = 1;
    if (reset) begin
      m_led = '0; m_stable = '0; m_changed = 0; m_prev = '0;
      hist[0] = '0; hist[1] = '0; k = 0;
    end else begin
      accept_now = 0;
      if (k % D == D - 1) begin
        if (hist[0] == m_prev && hist[0] != m_stable) begin
          m_stable = hist[0];
          accept_now = 1;
        end
        m_prev = hist[0];
      end
      if (accept_now) m_changed = 1;
      else if (switch_ctrl) m_changed = 0;
      if (led_ctrl) m_led = led_wdata;
      hist[0] = hist[1];
      hist[1] = switch_in;
      k++;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      vectors++;
      if (led_out !== m_led) begin
        miscompares++;
        $display("[TB] FAIL model_led_out t=%0t got %h want %h", $time, led_out, m_led);
      end
      vectors++;
      if (switch_rdata !== m_stable) begin
        miscompares++;
        $display("[TB] FAIL model_switch_rdata t=%0t got %h want %h", $time, switch_rdata, m_stable);
      end
      vectors++;
      if (sw_changed !== m_changed) begin
        miscompares++;
        $display("[TB] FAIL model_sw_changed t=%0t got %b want %b", $time, sw_changed, m_changed);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic lc, input logic [23:0] lw,
                               input logic sc, input logic [23:0] si);
    reset = r; led_ctrl = lc; led_wdata = lw; switch_ctrl = sc; switch_in = si;
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // Edges counted from the current inputs until switch_rdata shows exp.
  task automatic waitForRdata(input string name, input logic [23:0] exp,
                              input int min_edges, input int max_edges);
    int n = 0;
    bit seen = 0;
    while (!seen && n < max_edges + 2) begin
      @(negedge clock);
      n++;
      if (switch_rdata === exp) seen = 1;
    end
    checkOutput({name, "_seen"}, {23'd0, seen}, 24'd1);
    checkOutput({name, "_not_early"}, {23'd0, (n >= min_edges)}, 24'd1);
    checkOutput({name, "_in_time"}, {23'd0, (n <= max_edges)}, 24'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    logic [23:0] v;

    // Reset held with hostile inputs
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 24'hABCDEF, 0, 24'hFFFFFF);
      checkOutput("reset_led_out", led_out, 24'h0);
      checkOutput("reset_rdata", switch_rdata, 24'h0);
      checkOutput("reset_changed", {23'd0, sw_changed}, 24'h0);
    end

    // LED write, then hold
    applyStimulus(0, 1, 24'h00A5A5, 0, 24'h000000);
    checkOutput("led_write", led_out, 24'h00A5A5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 24'h123456, 0, 24'h000000);
      checkOutput("led_hold", led_out, 24'h00A5A5);
    end

    // Clean switch change
    applyStimulus(0, 0, 24'h123456, 0, 24'h000F0F);
    checkOutput("clean_pre_edge", switch_rdata, 24'h000000);
    waitForRdata("clean", 24'h000F0F, 6, 10);
    checkOutput("clean_changed", {23'd0, sw_changed}, 24'h1);

    // Settle bit0 low, then bounce it every cycle phased against the tick
    switch_in = 24'h000F0E;
    waitForRdata("clear_bit0", 24'h000F0E, 6, 10);
    for (int i = 0; i < 20; i++) begin
      v = 24'h000F0E;
      v[0] = (k % 2 == 1) ? 1'b0 : 1'b1;
      applyStimulus(0, 0, 24'h123456, 0, v);
      checkOutput("bounce_hold", switch_rdata, 24'h000F0E);
    end
    switch_in = 24'h000F0F;
    waitForRdata("bounce_settle", 24'h000F0F, 1, 10);

    // Read pulse clears the flag
    applyStimulus(0, 0, 24'h123456, 1, 24'h000F0F);
    checkOutput("read_clears", {23'd0, sw_changed}, 24'h0);
    checkOutput("read_rdata", switch_rdata, 24'h000F0F);
    applyStimulus(0, 0, 24'h123456, 0, 24'h000F0F);

    // Read held across the update edge: set wins
    switch_ctrl = 1; switch_in = 24'h00F0F0;
    waitForRdata("set_wins", 24'h00F0F0, 6, 10);
    checkOutput("set_wins_flag", {23'd0, sw_changed}, 24'h1);
    applyStimulus(0, 0, 24'h123456, 1, 24'h00F0F0);
    checkOutput("flag_cleared_after", {23'd0, sw_changed}, 24'h0);

    // Simultaneous LED write and read
    applyStimulus(0, 1, 24'h5A5A5A, 1, 24'h00F0F0);
    checkOutput("simul_led", led_out, 24'h5A5A5A);

    // Reset one tick into a pending change
    switch_ctrl = 0; led_ctrl = 0; switch_in = 24'h0A0A0A;
    guard = 0;
    while (m_prev !== 24'h0A0A0A && guard < 12) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("pending_sampled", {23'd0, (guard < 12)}, 24'h1);
    checkOutput("pending_not_taken", switch_rdata, 24'h00F0F0);
    applyStimulus(1, 0, 24'h123456, 0, 24'h0A0A0A);
    checkOutput("midrst_led", led_out, 24'h0);
    checkOutput("midrst_rdata", switch_rdata, 24'h0);
    checkOutput("midrst_changed", {23'd0, sw_changed}, 24'h0);
    reset = 0;
    waitForRdata("redebounce", 24'h0A0A0A, 6, 10);

    // Randomized traffic against the model
    v = switch_in;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) v = 24'($urandom);
        else v[$urandom_range(0, 23)] ^= 1'b1;
      end
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 24'($urandom),
                    $urandom_range(0, 7) == 0, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
